keypad_event_debouncer: RTL and testbench

- Parametrised successor to the keypad debouncer. Sits between the row/column keypad scanner and the key-consuming logic (display/FSM).
- Debounces both press and release, with configurable counts.
- Enforces that the key stays the same throughout debounce.
- Emits single-cycle press, release and typematic auto-repeat events, plus a binary key code, alongside the level key_valid.

---
 rtl/keypad_event_debouncer.sv | 147 ++++++++++++++
 tb/tb_keypad_event_debouncer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_event_debouncer.sv
// Keypad debouncer: press/release debounce on a one-hot row/col key, with
// single-cycle press, release and typematic repeat events.
module keypad_event_debouncer #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int PRESS_CNT    = 60000,
  parameter int RELEASE_CNT  = 30000,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 1500000,
  parameter int REPEAT_RATE  = 300000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            key_pressed,
  input  logic [ROWS-1:0]                 row_idx,
  input  logic [COLS-1:0]                 col_idx,
  output logic                            key_valid,
  output logic [ROWS-1:0]                 key_row,
  output logic [COLS-1:0]                 key_col,
  output logic [$clog2(ROWS*COLS)-1:0]    key_code,
  output logic                            press_pulse,
  output logic                            release_pulse,
  output logic                            repeat_pulse
);

  localparam int CW     = $clog2(ROWS*COLS);
  localparam int DB_MAX = (PRESS_CNT > RELEASE_CNT) ? PRESS_CNT : RELEASE_CNT;
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int DBW    = $clog2(DB_MAX + 1);
  localparam int RPW    = $clog2(RP_MAX + 1);

  localparam logic [DBW-1:0] PRESS_LAST   = DBW'(PRESS_CNT - 1);
  localparam logic [DBW-1:0] RELEASE_LAST = DBW'(RELEASE_CNT - 1);
  localparam logic [RPW-1:0] DELAY_LAST   = RPW'(REPEAT_DELAY - 1);
  localparam logic [RPW-1:0] RATE_LAST    = RPW'(REPEAT_RATE - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DEB  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;

  logic [1:0]      state;
  logic [DBW-1:0]  cnt;
  logic [RPW-1:0]  rpt_cnt;
  logic            rpt_first;
  logic [ROWS-1:0] cand_row;
  logic [COLS-1:0] cand_col;
  logic [CW-1:0]   cand_code;
  logic            sample_ok;
  logic            match;
  logic [RPW-1:0]  rpt_last;

  assign sample_ok = key_pressed && $onehot(row_idx) && $onehot(col_idx);
  assign match     = sample_ok && (row_idx == cand_row) && (col_idx == cand_col);
  assign rpt_last  = rpt_first ? DELAY_LAST : RATE_LAST;

  always_comb begin
    cand_code = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (cand_row[r] && cand_col[c]) cand_code = CW'(r*COLS + c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      rpt_cnt       <= '0;
      rpt_first     <= 1'b0;
      cand_row      <= '0;
      cand_col      <= '0;
      key_valid     <= 1'b0;
      key_row       <= '0;
      key_col       <= '0;
      key_code      <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sample_ok) begin
            cand_row <= row_idx;
            cand_col <= col_idx;
            cnt      <= '0;
            state    <= S_DEB;
          end
        end
        S_DEB: begin
          if (!match) begin
            state    <= S_IDLE;
            cand_row <= '0;
            cand_col <= '0;
            cnt      <= '0;
          end else if (cnt == PRESS_LAST) begin
            state       <= S_HOLD;
            cnt         <= '0;
            key_valid   <= 1'b1;
            key_row     <= cand_row;
            key_col     <= cand_col;
            key_code    <= cand_code;
            press_pulse <= 1'b1;
            rpt_cnt     <= '0;
            rpt_first   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (!match) begin
            state <= S_REL;
            cnt   <= '0;
          end else if (REPEAT_EN != 0) begin
            // Reload rather than free-run so the counter never wraps.
            if (rpt_cnt == rpt_last) begin
              repeat_pulse <= 1'b1;
              rpt_cnt      <= '0;
              rpt_first    <= 1'b0;
            end else begin
              rpt_cnt <= rpt_cnt + 1'b1;
            end
          end
        end
        default: begin
          // Release debounce: repeat counter is left frozen until HOLD resumes.
          if (match) begin
            state <= S_HOLD;
            cnt   <= '0;
          end else if (cnt == RELEASE_LAST) begin
            state         <= S_IDLE;
            cnt           <= '0;
            cand_row      <= '0;
            cand_col      <= '0;
            key_valid     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_event_debouncer.sv
// Randomised + directed bench for keypad_event_debouncer: a reference model
// queues expected events, a monitor pops and compares whenever the DUT pulses.
module tb_keypad_event_debouncer;

  localparam int P_CNT = 4;
  localparam int R_CNT = 3;
  localparam int DELAY = 10;
  localparam int RATE  = 4;
  localparam int MAXE  = 50000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_pressed = 1'b0;
  logic [3:0] row_idx = '0;
  logic [3:0] col_idx = '0;
  logic       key_valid;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [3:0] key_code;
  logic       press_pulse;
  logic       release_pulse;
  logic       repeat_pulse;

  keypad_event_debouncer #(
    .ROWS(4), .COLS(4), .PRESS_CNT(P_CNT), .RELEASE_CNT(R_CNT),
    .REPEAT_EN(1), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_pressed(key_pressed),
    .row_idx(row_idx), .col_idx(col_idx), .key_valid(key_valid),
    .key_row(key_row), .key_col(key_col), .key_code(key_code),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] kind;  // {press, release, repeat}
    int         code;
    int         t;
  } ev_t;

  ev_t exp_q[$];
  bit  exp_kv [0:MAXE-1];
  int  edge_n = 0;
  int  checks = 0;
  int  errors = 0;
  int  n_press = 0, n_rel = 0, n_rep = 0, last_code = -1;
  bit  rst_release_pending = 1'b0;

  // Reference model: key-level rules expressed with plain integers.
  int m_phase = 0;   // 0 idle, 1 pressing, 2 held, 3 releasing
  int m_cand = -1, m_streak = 0, m_rel = 0, m_age = 0, m_acc = 0;
  bit m_kv = 1'b0;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic void chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d (edge %0d)", nm, got, exp, edge_n);
    end
  endfunction

  function automatic int samp_code(logic kp, logic [3:0] r, logic [3:0] c);
    int ri, ci;
    ri = -1; ci = -1;
    if (!kp || $countones(r) != 1 || $countones(c) != 1) return -1;
    for (int i = 0; i < 4; i++) begin
      if (r[i]) ri = i;
      if (c[i]) ci = i;
    end
    return ri*4 + ci;
  endfunction

  function automatic bit rep_due(int age);
    if (age == DELAY) return 1'b1;
    return (age > DELAY) && ((age - DELAY) % RATE == 0);
  endfunction

  function automatic void ev_push(logic [2:0] k, int code, int t);
    ev_t e;
    e.kind = k; e.code = code; e.t = t;
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_cand = -1; m_streak = 0; m_rel = 0; m_age = 0; m_kv = 1'b0;
  endfunction

  function automatic void model_edge(int s, int t);
    case (m_phase)
      0: if (s >= 0) begin m_cand = s; m_streak = 0; m_phase = 1; end
      1: begin
        if (s != m_cand) begin m_phase = 0; m_cand = -1; end
        else if (m_streak == P_CNT-1) begin
          m_phase = 2; m_acc = m_cand; m_kv = 1'b1; m_age = 0;
          ev_push(3'b100, m_acc, t);
        end else m_streak++;
      end
      2: begin
        if (s == m_cand) begin
          m_age++;
          if (rep_due(m_age)) ev_push(3'b001, m_acc, t);
        end else begin m_phase = 3; m_rel = 0; end
      end
      default: begin
        if (s == m_cand) m_phase = 2;
        else if (m_rel == R_CNT-1) begin
          m_phase = 0; m_kv = 1'b0; m_cand = -1;
          ev_push(3'b010, m_acc, t);
        end else m_rel++;
      end
    endcase
    exp_kv[t] = m_kv;
  endfunction

  task automatic step(input logic kp, input logic [3:0] r, input logic [3:0] c);
    @(negedge clk);
    if (rst_release_pending) begin rst_n = 1'b1; rst_release_pending = 1'b0; end
    key_pressed = kp; row_idx = r; col_idx = c;
    if (!rst_n) begin
      model_reset();
      exp_kv[edge_n+1] = 1'b0;
    end else begin
      model_edge(samp_code(kp, r, c), edge_n + 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'b0000, 4'b0000);
  endtask

  // Monitor: per-cycle key_valid level plus event scoreboard.
  logic [2:0] got;
  ev_t        me;
  logic [3:0] er, ec;
  always @(negedge clk) begin
    chk("key_valid", int'(key_valid), int'(exp_kv[edge_n]));
    got = {press_pulse, release_pulse, repeat_pulse};
    if (press_pulse) begin n_press++; last_code = int'(key_code); end
    if (release_pulse) n_rel++;
    if (repeat_pulse) n_rep++;
    if (got != 3'b000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event kind=%b code=%0d at edge %0d, none expected",
                 got, key_code, edge_n);
      end else begin
        me = exp_q.pop_front();
        er = 4'(1 << (me.code / 4));
        ec = 4'(1 << (me.code % 4));
        if (me.kind != got || me.t != edge_n || me.code != int'(key_code) ||
            key_row != er || key_col != ec) begin
          errors++;
          $display("FAIL event got kind=%b code=%0d row=%b col=%b at edge %0d, expected kind=%b code=%0d row=%b col=%b at edge %0d",
                   got, key_code, key_row, key_col, edge_n, me.kind, me.code, er, ec, me.t);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].t <= edge_n) begin
      checks++; errors++;
      me = exp_q.pop_front();
      $display("FAIL missed_event got none at edge %0d, expected kind=%b code=%0d at edge %0d",
               edge_n, me.kind, me.code, me.t);
    end
  end

  int b_p, b_r, b_x;
  task automatic mark();
    @(posedge clk); #1;
    b_p = n_press; b_r = n_rel; b_x = n_rep;
  endtask
  task automatic deltas(input string nm, input int p, input int r, input int x);
    @(posedge clk); #1;
    chk({nm, "_press_count"}, n_press - b_p, p);
    chk({nm, "_release_count"}, n_rel - b_r, r);
    chk({nm, "_repeat_count"}, n_rep - b_x, x);
  endtask

  int kind_sel, dur;
  logic [3:0] rr, cc;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_key_valid", int'(key_valid), 0);
    chk("reset_key_code", int'(key_code), 0);
    chk("reset_pulses", int'({press_pulse, release_pulse, repeat_pulse}), 0);
    rst_release_pending = 1'b1;
    idle(3);

    // Clean press: code 6, repeats at HOLD cycles 10 and 14.
    mark();
    repeat (20) step(1'b1, 4'b0010, 4'b0100);
    idle(8);
    deltas("clean", 1, 1, 2);
    chk("clean_code", last_code, 6);

    // Press bounce.
    mark();
    repeat (3) step(1'b1, 4'b0100, 4'b0010);
    idle(1);
    repeat (10) step(1'b1, 4'b0100, 4'b0010);
    idle(8);
    deltas("bounce", 1, 1, 0);

    // Key change mid-debounce.
    mark();
    repeat (2) step(1'b1, 4'b0001, 4'b0001);
    repeat (8) step(1'b1, 4'b0001, 4'b0010);
    idle(8);
    deltas("change", 1, 1, 0);
    chk("change_code", last_code, 1);

    // Release bounce.
    mark();
    repeat (8) step(1'b1, 4'b1000, 4'b1000);
    idle(2);
    step(1'b1, 4'b1000, 4'b1000);
    idle(6);
    deltas("relbounce", 1, 1, 0);

    // Invalid indices.
    mark();
    repeat (50) step(1'b1, 4'b0001, 4'b0110);
    repeat (50) step(1'b1, 4'b0000, 4'b0100);
    deltas("invalid", 0, 0, 0);

    // Async reset mid-HOLD.
    mark();
    repeat (12) step(1'b1, 4'b0010, 4'b0001);
    @(posedge clk); #2;
    rst_n = 1'b0;
    while (exp_q.size() > 0 && exp_q[$].t >= edge_n) void'(exp_q.pop_back());
    exp_kv[edge_n] = 1'b0;
    #1;
    chk("async_rst_key_valid", int'(key_valid), 0);
    chk("async_rst_key_code", int'(key_code), 0);
    chk("async_rst_key_row", int'(key_row), 0);
    chk("async_rst_pulses", int'({press_pulse, release_pulse, repeat_pulse}), 0);
    model_reset();
    repeat (2) step(1'b1, 4'b0010, 4'b0001);
    rst_release_pending = 1'b1;
    repeat (10) step(1'b1, 4'b0010, 4'b0001);
    idle(8);
    deltas("reset", 2, 1, 0);

    // Randomised segments.
    for (int seg = 0; seg < 150; seg++) begin
      kind_sel = $urandom_range(0, 9);
      if (kind_sel < 5) begin
        rr = 4'(1 << $urandom_range(0, 3));
        cc = 4'(1 << $urandom_range(0, 3));
        dur = $urandom_range(1, 30);
        for (int i = 0; i < dur; i++) begin
          if ($urandom_range(0, 9) == 0) step(1'b0, rr, cc);
          else step(1'b1, rr, cc);
        end
      end else if (kind_sel < 8) begin
        idle($urandom_range(1, 12));
      end else begin
        dur = $urandom_range(1, 15);
        for (int i = 0; i < dur; i++)
          step(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
    end
    idle(12);
    @(posedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
